// File: rtl/fsl_uart_pkg.sv
// Shared encodings and elaboration helpers for the FSL<->RS232 bridge.
// FSL_UART_PARITY_EN adds the PARITY states.
package fsl_uart_pkg;

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_STOP   = 3'd3;
  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_STOP   = 3'd3;
`ifdef FSL_UART_PARITY_EN
  localparam logic [2:0] TX_PARITY = 3'd4;
  localparam logic [2:0] RX_PARITY = 3'd4;
`endif

  // Cycles per bit, rounded to nearest.
  function automatic int baud_div(input int freq, input int baud);
    return (freq + baud / 2) / baud;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/fsl_uart_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty come from the registered count,
// so a push while full is refused even if a pop happens in the same cycle.
module fsl_uart_fifo
  import fsl_uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rp];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock)
    if (do_push) mem[wp] <= wr_data;

endmodule

// File: rtl/fsl_uart_bridge.sv
// Buffered FSL<->RS232 bridge with configurable framing and RTS/CTS flow control.
// FSL bit 0 is the MSB, so FSL bits [32-DATA_BITS:31] are [DATA_BITS-1:0] here.
// Define FSL_UART_PARITY_EN to add a parity bit (odd when PARITY_ODD=1).
module fsl_uart_bridge
  import fsl_uart_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int DATA_BITS     = 8,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 16,
  parameter int PARITY_ODD    = 0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        rs232_tx_data_o,
  input  logic        rs232_rx_data_i,
  input  logic        rs232_rts_i,
  output logic        rs232_cts_o,
  output logic        rx_overrun_o,
  output logic        FSL_S_CLK,
  input  logic [31:0] FSL_S_DATA,
  input  logic        FSL_S_CONTROL,
  input  logic        FSL_S_EXISTS,
  output logic        FSL_S_READ,
  output logic        FSL_M_CLK,
  output logic [31:0] FSL_M_DATA,
  output logic        FSL_M_CONTROL,
  input  logic        FSL_M_FULL,
  output logic        FSL_M_WRITE
);

  localparam int DIV = baud_div(CLOCK_FREQ_HZ, BAUD_RATE);
  localparam int CW  = clog2(STOP_BITS * DIV + 1);
  localparam int BW  = clog2(DATA_BITS);
  localparam int FW  = clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  logic [DATA_BITS-1:0] tx_head;
  logic [DATA_BITS:0]   rx_head, rx_wdata;
  logic                 tx_full, tx_empty, tx_pop, tx_go, tx_tick;
  logic                 rx_full, rx_empty, rx_push, rx_err, rx_tick;
  logic [FW:0]          tx_count, rx_count;
  logic                 unused_ok;

  assign FSL_S_CLK     = clock;
  assign FSL_M_CLK     = clock;
  assign FSL_S_READ    = FSL_S_EXISTS & ~tx_full & ~reset;
  assign FSL_M_WRITE   = ~rx_empty & ~FSL_M_FULL & ~reset;
  assign FSL_M_DATA    = 32'(rx_head[DATA_BITS-1:0]);
  assign FSL_M_CONTROL = rx_head[DATA_BITS];
  assign unused_ok     = ^{FSL_S_CONTROL, FSL_S_DATA[31:DATA_BITS], tx_count, ODD};

  fsl_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock(clock), .reset(reset), .push(FSL_S_READ), .wr_data(FSL_S_DATA[DATA_BITS-1:0]),
    .pop(tx_pop), .rd_data(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count));

  fsl_uart_fifo #(.WIDTH(DATA_BITS + 1), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock(clock), .reset(reset), .push(rx_push), .wr_data(rx_wdata),
    .pop(FSL_M_WRITE), .rd_data(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count));

  // ---------------- transmitter ----------------
  logic [2:0]           tx_st;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par;

  // End of STOP doubles as an IDLE decision point so characters run back to back.
  assign tx_go   = ~tx_empty & ~rs232_rts_i;
  assign tx_tick = (tx_cnt == BIT_END);
  assign tx_pop  = tx_go & ((tx_st == TX_IDLE) | ((tx_st == TX_STOP) & (tx_cnt == STOP_END)));

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_st           <= TX_IDLE;
      tx_cnt          <= '0;
      tx_bit          <= '0;
      tx_sh           <= '0;
      tx_par          <= 1'b0;
      rs232_tx_data_o <= 1'b1;
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
      if (tx_pop) begin
        tx_st           <= TX_START;
        tx_cnt          <= '0;
        tx_sh           <= tx_head;
        tx_par          <= ^tx_head ^ ODD;
        rs232_tx_data_o <= 1'b0;
      end else begin
        case (tx_st)
          TX_IDLE: tx_cnt <= '0;
          TX_START: if (tx_tick) begin
            tx_st           <= TX_DATA;
            tx_cnt          <= '0;
            tx_bit          <= '0;
            rs232_tx_data_o <= tx_sh[0];
            tx_sh           <= tx_sh >> 1;
          end
          TX_DATA: if (tx_tick) begin
            tx_cnt <= '0;
            if (tx_bit == LAST_BIT) begin
`ifdef FSL_UART_PARITY_EN
              tx_st           <= TX_PARITY;
              rs232_tx_data_o <= tx_par;
`else
              tx_st           <= TX_STOP;
              rs232_tx_data_o <= 1'b1;
`endif
            end else begin
              tx_bit          <= tx_bit + 1'b1;
              rs232_tx_data_o <= tx_sh[0];
              tx_sh           <= tx_sh >> 1;
            end
          end
`ifdef FSL_UART_PARITY_EN
          TX_PARITY: if (tx_tick) begin
            tx_st           <= TX_STOP;
            tx_cnt          <= '0;
            rs232_tx_data_o <= 1'b1;
          end
`endif
          TX_STOP: if (tx_cnt == STOP_END) begin
            tx_st  <= TX_IDLE;
            tx_cnt <= '0;
          end
          default: tx_st <= TX_IDLE;
        endcase
      end
    end
  end

  // ---------------- receiver ----------------
  logic [1:0]           rx_sync;
  logic                 rx_s, rx_d, rx_perr;
  logic [2:0]           rx_st;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_sh;

  assign rx_s     = rx_sync[1];
  assign rx_tick  = (rx_cnt == BIT_END);
  assign rx_push  = (rx_st == RX_STOP) & rx_tick;
`ifdef FSL_UART_PARITY_EN
  assign rx_err   = ~rx_s | rx_perr;
`else
  assign rx_err   = ~rx_s | (rx_perr & 1'b0);
`endif
  assign rx_wdata = {rx_err, rx_sh};

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_sync      <= 2'b11;
      rx_d         <= 1'b1;
      rx_st        <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_sh        <= '0;
      rx_perr      <= 1'b0;
      rx_overrun_o <= 1'b0;
      rs232_cts_o  <= 1'b0;
    end else begin
      rx_sync     <= {rx_sync[0], rs232_rx_data_i};
      rx_d        <= rx_s;
      rx_cnt      <= rx_cnt + 1'b1;
      rs232_cts_o <= (rx_count >= (FW+1)'(FIFO_DEPTH - 1));
      if (rx_push & rx_full) rx_overrun_o <= 1'b1;
      case (rx_st)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_d & ~rx_s) rx_st <= RX_START;
        end
        // Half a bit after the edge the line must still be low, else it was a glitch.
        RX_START: if (rx_cnt == HALF_END) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_st  <= rx_s ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_tick) begin
          rx_cnt <= '0;
          rx_bit <= rx_bit + 1'b1;
          rx_sh  <= {rx_s, rx_sh[DATA_BITS-1:1]};
`ifdef FSL_UART_PARITY_EN
          if (rx_bit == LAST_BIT) rx_st <= RX_PARITY;
`else
          if (rx_bit == LAST_BIT) rx_st <= RX_STOP;
`endif
        end
`ifdef FSL_UART_PARITY_EN
        RX_PARITY: if (rx_tick) begin
          rx_cnt  <= '0;
          rx_perr <= ^rx_sh ^ rx_s ^ ODD;
          rx_st   <= RX_STOP;
        end
`endif
        RX_STOP: if (rx_tick) rx_st <= RX_IDLE;
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

endmodule
